// File: rtl/alu_share_arbiter_pkg.sv
// rtl/alu_share_arbiter_pkg.sv - shared constants for the ALU sharing arbiter
// Purpose: ALU opcode encodings, ALU pipeline depth and an ID-width helper.
// Ports: none (package).
package alu_share_arbiter_pkg;

  localparam int ALUOP_W     = 4;
  // Cycles from operand issue to result; sizes the response valid/id pipeline.
  localparam int ALU_LATENCY = 1;

  localparam logic [ALUOP_W-1:0] ADD_OP  = 4'd0;
  localparam logic [ALUOP_W-1:0] SUB_OP  = 4'd1;
  localparam logic [ALUOP_W-1:0] SLL_OP  = 4'd2;
  localparam logic [ALUOP_W-1:0] SLT_OP  = 4'd3;
  localparam logic [ALUOP_W-1:0] SLTU_OP = 4'd4;
  localparam logic [ALUOP_W-1:0] XOR_OP  = 4'd5;
  localparam logic [ALUOP_W-1:0] SRL_OP  = 4'd6;
  localparam logic [ALUOP_W-1:0] SRA_OP  = 4'd7;
  localparam logic [ALUOP_W-1:0] OR_OP   = 4'd8;
  localparam logic [ALUOP_W-1:0] AND_OP  = 4'd9;
  localparam logic [ALUOP_W-1:0] PASS_OP = 4'd10;

  // Index width for n requesters; a single requester still needs one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// rtl/alu_share_arbiter_if.sv - requester/response bus of the ALU sharing arbiter
// Purpose: bundles the packed request lanes, stall, grant and response bus.
// Ports (signals): i_req_valid/i_req_op1/i_req_op2/i_req_aluop/i_stall driven by
//   requesters (master); o_req_ready/o_rsp_valid/o_rsp_id/o_rsp_result driven by
//   the arbiter (slave). Requester k occupies lane [k*W +: W] of packed buses.
interface alu_share_arbiter_if
  import alu_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DWIDTH      = 32,
  parameter int ALUOP_WIDTH = 4
);
  localparam int ID_W = id_width(NUM_REQ);

  logic [NUM_REQ-1:0]             i_req_valid;
  logic [NUM_REQ*DWIDTH-1:0]      i_req_op1;
  logic [NUM_REQ*DWIDTH-1:0]      i_req_op2;
  logic [NUM_REQ*ALUOP_WIDTH-1:0] i_req_aluop;
  logic                           i_stall;
  logic [NUM_REQ-1:0]             o_req_ready;
  logic                           o_rsp_valid;
  logic [ID_W-1:0]                o_rsp_id;
  logic [DWIDTH-1:0]              o_rsp_result;

  modport master (
    output i_req_valid, i_req_op1, i_req_op2, i_req_aluop, i_stall,
    input  o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_result
  );

  modport slave (
    input  i_req_valid, i_req_op1, i_req_op2, i_req_aluop, i_stall,
    output o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_result
  );

endinterface

// File: rtl/alu_share_arbiter_alu.sv
// rtl/alu_share_arbiter_alu.sv - registered integer ALU
// Purpose: computes op1 <aluop> op2 and registers the result (no reset).
// Ports: clk; i_op1/i_op2 operands; i_aluop opcode; o_result registered result.
module alu
  import alu_share_arbiter_pkg::*;
#(
  parameter int DWIDTH      = 32,
  parameter int ALUOP_WIDTH = 4
) (
  input  logic                   clk,
  input  logic [DWIDTH-1:0]      i_op1,
  input  logic [DWIDTH-1:0]      i_op2,
  input  logic [ALUOP_WIDTH-1:0] i_aluop,
  output logic [DWIDTH-1:0]      o_result
);
  localparam int SH_W = $clog2(DWIDTH);

  logic [DWIDTH-1:0] result_d, result_q;
  logic [SH_W-1:0]   shamt;

  assign shamt = i_op2[SH_W-1:0];

  always_comb begin
    result_d = '0;
    unique case (i_aluop)
      ALUOP_WIDTH'(ADD_OP):  result_d = i_op1 + i_op2;
      ALUOP_WIDTH'(SUB_OP):  result_d = i_op1 - i_op2;
      ALUOP_WIDTH'(SLL_OP):  result_d = i_op1 << shamt;
      ALUOP_WIDTH'(SLT_OP):  result_d = {{(DWIDTH-1){1'b0}}, $signed(i_op1) < $signed(i_op2)};
      ALUOP_WIDTH'(SLTU_OP): result_d = {{(DWIDTH-1){1'b0}}, i_op1 < i_op2};
      ALUOP_WIDTH'(XOR_OP):  result_d = i_op1 ^ i_op2;
      ALUOP_WIDTH'(SRL_OP):  result_d = i_op1 >> shamt;
      ALUOP_WIDTH'(SRA_OP):  result_d = $unsigned($signed(i_op1) >>> shamt);
      ALUOP_WIDTH'(OR_OP):   result_d = i_op1 | i_op2;
      ALUOP_WIDTH'(AND_OP):  result_d = i_op1 & i_op2;
      ALUOP_WIDTH'(PASS_OP): result_d = i_op2;
      default:               result_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    result_q <= result_d;
  end

  assign o_result = result_q;

endmodule

// File: rtl/alu_share_arbiter_rr_picker.sv
// rtl/alu_share_arbiter_rr_picker.sv - combinational round-robin picker
// Purpose: picks the first set request scanning from i_ptr upward with wrap.
// Ports: i_req request vector; i_ptr scan start; o_grant one-hot-or-zero;
//   o_grant_idx index of the grant; o_grant_valid any grant issued.
module rr_picker #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_grant_idx,
  output logic          o_grant_valid
);

  always_comb begin
    int idx;
    o_grant       = '0;
    o_grant_idx   = '0;
    o_grant_valid = 1'b0;
    idx           = 0;
    for (int off = 0; off < N; off++) begin
      idx = (int'(i_ptr) + off) % N;
      if (!o_grant_valid && i_req[idx]) begin
        o_grant_valid = 1'b1;
        o_grant[idx]  = 1'b1;
        o_grant_idx   = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one registered ALU
// Purpose: grants one requester per cycle, muxes its operands into the ALU and
//   returns the result one cycle later tagged with the requester ID.
// Ports: clk; reset (sync, active-high); bus (slave modport) carrying request
//   lanes, stall, grant and the response valid/id/result.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DWIDTH      = 32,
  parameter int ALUOP_WIDTH = 4
) (
  input logic                clk,
  input logic                reset,
  alu_share_arbiter_if.slave bus
);
  localparam int ID_W = id_width(NUM_REQ);

  logic [NUM_REQ-1:0]                 req_eligible;
  logic [NUM_REQ-1:0]                 grant;
  logic [ID_W-1:0]                    grant_idx;
  logic                               grant_valid;
  logic [ID_W-1:0]                    ptr_d, ptr_q;
  logic [ALU_LATENCY-1:0]             rsp_valid_d, rsp_valid_q;
  logic [ALU_LATENCY-1:0][ID_W-1:0]   rsp_id_d, rsp_id_q;
  logic [DWIDTH-1:0]                  alu_op1, alu_op2, alu_result;
  logic [ALUOP_WIDTH-1:0]             alu_aluop;

  // Stall and reset suppress every grant; ready never feeds back into the pick.
  assign req_eligible = (reset || bus.i_stall) ? '0 : bus.i_req_valid;

  rr_picker #(.N(NUM_REQ)) u_picker (
    .i_req        (req_eligible),
    .i_ptr        (ptr_q),
    .o_grant      (grant),
    .o_grant_idx  (grant_idx),
    .o_grant_valid(grant_valid)
  );

  assign bus.o_req_ready = grant;

  // Idle cycles drive a benign PASS of zero so the ALU inputs are never X.
  always_comb begin
    alu_op1   = '0;
    alu_op2   = '0;
    alu_aluop = ALUOP_WIDTH'(PASS_OP);
    if (grant_valid) begin
      alu_op1   = bus.i_req_op1[int'(grant_idx)*DWIDTH +: DWIDTH];
      alu_op2   = bus.i_req_op2[int'(grant_idx)*DWIDTH +: DWIDTH];
      alu_aluop = bus.i_req_aluop[int'(grant_idx)*ALUOP_WIDTH +: ALUOP_WIDTH];
    end
  end

  alu #(.DWIDTH(DWIDTH), .ALUOP_WIDTH(ALUOP_WIDTH)) u_alu (
    .clk     (clk),
    .i_op1   (alu_op1),
    .i_op2   (alu_op2),
    .i_aluop (alu_aluop),
    .o_result(alu_result)
  );

  always_comb begin
    ptr_d = ptr_q;
    if (grant_valid) begin
      ptr_d = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
    end
    // Valid/id travel alongside the ALU pipeline so they line up with the result.
    rsp_valid_d    = '0;
    rsp_id_d       = '0;
    rsp_valid_d[0] = grant_valid;
    rsp_id_d[0]    = grant_idx;
    for (int i = 1; i < ALU_LATENCY; i++) begin
      rsp_valid_d[i] = rsp_valid_q[i-1];
      rsp_id_d[i]    = rsp_id_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q       <= '0;
      rsp_valid_q <= '0;
      rsp_id_q    <= '0;
    end else begin
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign bus.o_rsp_valid  = rsp_valid_q[ALU_LATENCY-1];
  assign bus.o_rsp_id     = rsp_id_q[ALU_LATENCY-1];
  assign bus.o_rsp_result = alu_result;

endmodule
